// File: rtl/man_norm_pack.sv
// Normalize-and-pack back end of the FP add/sub mantissa path: carry right
// shift or iterative left shift with exponent tracking, then {sign,exp,frac}.
module man_norm_pack #(
  parameter int SIZE_MAN = 24,
  parameter int SIZE_EXP = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_sign,
  input  logic [SIZE_EXP-1:0]          i_exp,
  input  logic [SIZE_MAN:0]            i_man,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [SIZE_EXP+SIZE_MAN-1:0] o_result,
  output logic                         o_zero,
  output logic                         o_ovf,
  output logic                         o_unf
);

  localparam int EW = SIZE_EXP + 1;
  localparam logic [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [EW-1:0] EXP_MAX = {1'b0, {SIZE_EXP{1'b1}}};

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t             state_q;
  logic               sign_q;
  logic [EW-1:0]      exp_q;
  logic [SIZE_MAN:0]  man_q;
  logic               zero_q;
  logic               ovf_q;
  logic               unf_q;
  logic [EW-1:0]      exp_inc;

  // The extra exponent bit lets the carry increment be tested without wrap.
  function automatic logic exp_saturates(input logic [EW-1:0] e);
    return e >= EXP_MAX;
  endfunction

  assign exp_inc = exp_q + EXP_ONE;
  assign o_ready = (state_q == IDLE) && !i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zero   <= 1'b0;
      o_ovf    <= 1'b0;
      o_unf    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            sign_q  <= i_sign;
            exp_q   <= {1'b0, i_exp};
            man_q   <= i_man;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (man_q == '0) begin
            exp_q   <= '0;
            zero_q  <= 1'b1;
            state_q <= DONE;
          end else if (man_q[SIZE_MAN]) begin
            if (exp_saturates(exp_inc)) begin
              exp_q <= EXP_MAX;
              man_q <= '0;
              ovf_q <= 1'b1;
            end else begin
              exp_q <= exp_inc;
              man_q <= man_q >> 1;
            end
            state_q <= DONE;
          end else if (man_q[SIZE_MAN-1]) begin
            state_q <= DONE;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (man_q[SIZE_MAN-1]) begin
            state_q <= DONE;
          end else if (exp_q <= EXP_ONE) begin
            // Out of exponent range: leave the fraction as a subnormal.
            exp_q   <= '0;
            unf_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            man_q <= man_q << 1;
            exp_q <= exp_q - EXP_ONE;
          end
        end
        DONE: begin
          if (!o_valid) begin
            o_valid  <= 1'b1;
            o_result <= {sign_q, exp_q[SIZE_EXP-1:0], man_q[SIZE_MAN-2:0]};
            o_zero   <= zero_q;
            o_ovf    <= ovf_q;
            o_unf    <= unf_q;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            o_zero  <= 1'b0;
            o_ovf   <= 1'b0;
            o_unf   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_man_norm_pack.sv
// Directed-vector bench for man_norm_pack (default 24/8 single-precision sizing).
module tb_man_norm_pack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready_dut;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_man;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        unf;

  int n_chk  = 0;
  int n_fail = 0;

  man_norm_pack #(.SIZE_MAN(24), .SIZE_EXP(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (in_valid),
    .o_ready  (out_ready_dut),
    .i_sign   (in_sign),
    .i_exp    (in_exp),
    .i_man    (in_man),
    .o_valid  (out_valid),
    .i_ready  (in_ready),
    .o_result (result),
    .o_zero   (zero),
    .o_ovf    (ovf),
    .o_unf    (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] man;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        u;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Accept an operand, measure cycles to o_valid, compare, then complete handshake.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    check({tag, " ready_before"}, 32'(out_ready_dut), 32'd1);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_man   = v.man;
    in_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(v.lat));
    check({tag, " result"}, result, v.res);
    check({tag, " flags"}, {29'd0, zero, ovf, unf}, {29'd0, v.z, v.o, v.u});
    @(negedge clk);
    in_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " valid_cleared"}, 32'(out_valid), 32'd0);
    check({tag, " back_to_idle"}, 32'(out_ready_dut), 32'd1);
    in_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    vecs[0]  = '{1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{1'b0, 8'h7F, 25'h1000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 2};
    vecs[2]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1'b0, 1'b1, 1'b0, 2};
    vecs[3]  = '{1'b0, 8'h7F, 25'h0200000, 32'h3E800000, 1'b0, 1'b0, 1'b0, 5};
    vecs[4]  = '{1'b1, 8'h55, 25'h0000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 2};
    vecs[5]  = '{1'b0, 8'h01, 25'h0400000, 32'h00400000, 1'b0, 1'b0, 1'b1, 3};
    vecs[6]  = '{1'b0, 8'h00, 25'h0000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 3};
    vecs[7]  = '{1'b1, 8'h80, 25'h1800001, 32'hC0C00000, 1'b0, 1'b0, 1'b0, 2};
    vecs[8]  = '{1'b0, 8'h7F, 25'h0000001, 32'h34000000, 1'b0, 1'b0, 1'b0, 26};
    vecs[9]  = '{1'b0, 8'h03, 25'h0100000, 32'h00400000, 1'b0, 1'b0, 1'b1, 5};
    vecs[10] = '{1'b0, 8'hFD, 25'h1000000, 32'h7F000000, 1'b0, 1'b0, 1'b0, 2};
    vecs[11] = '{1'b0, 8'hFF, 25'h1FFFFFF, 32'h7F800000, 1'b0, 1'b1, 1'b0, 2};

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0; in_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(out_ready_dut), 32'd0);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", {29'd0, zero, ovf, unf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held, no second accept while stalled in DONE.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_man = 25'h0800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    held = result;
    check("bp first result", held, 32'h3F800000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_exp = 8'h10; in_man = 25'h1000000;
      check("bp ready low", 32'(out_ready_dut), 32'd0);
      @(posedge clk); #1;
      check("bp valid held", 32'(out_valid), 32'd1);
      check("bp result held", result, held);
    end
    @(negedge clk);
    in_valid = 1'b0; in_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release valid", 32'(out_valid), 32'd0);
    check("bp release idle", 32'(out_ready_dut), 32'd1);
    in_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp no ghost accept", 32'(out_valid), 32'd0);

    // Reset while iterating left shifts.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_man = 25'h0000001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre-reset stale result", result, 32'h3F800000);
    rst = 1'b1;
    #1;
    check("midrst valid", 32'(out_valid), 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst ready", 32'(out_ready_dut), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[3], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
